// File: rtl/bmp_pkg.sv
// Shared constants and engine-side state type for the bitmap loader.
package bmp_pkg;

    localparam int BMP_W   = 1536;
    localparam int WORD_W  = 32;
    localparam int NWORDS  = 48;
    localparam int RES_W   = 16;
    localparam int FRAME_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } eng_state_t;

endpackage

// File: rtl/bmp_fill_buf.sv
// Fill side of the loader: assembles stream words into a full bitmap.
// Optional framing check on in_last enabled by BMP_LOADER_LASTCHK_EN.
module bmp_fill_buf
    import bmp_pkg::*;
#(
    parameter int WORD_W = bmp_pkg::WORD_W,
    parameter int NWORDS = bmp_pkg::NWORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              issue,
    output logic [BMP_W-1:0]  fill_data,
    output logic              fill_full,
    output logic              err
);

    localparam int               CNT_W    = $clog2(NWORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             rdy_q;
    logic             xfer;
    logic             last_pos;
    logic             bad_last;
    logic [BMP_W-1:0] fill_q;

    assign xfer     = in_valid & rdy_q;
    assign last_pos = (cnt_q == LAST_IDX);

`ifdef BMP_LOADER_LASTCHK_EN
    logic err_q;

    assign bad_last = in_last ^ last_pos;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (xfer && bad_last) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_last;

    assign unused_last = in_last;
    assign bad_last    = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        full_d = full_q;
        if (issue) begin
            full_d = 1'b0;
        end
        if (xfer) begin
            if (bad_last) begin
                cnt_d = '0;
            end else if (last_pos) begin
                cnt_d  = '0;
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // in_ready is registered from the next-state full flag so it drops with fill_full
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
            rdy_q  <= !full_d;
        end
    end

    // Data needs no reset: a frame is only handed on once every word has been rewritten.
    always_ff @(posedge clk) begin
        if (xfer) begin
            fill_q[int'(cnt_q)*WORD_W +: WORD_W] <= in_data;
        end
    end

    assign fill_data = fill_q;
    assign fill_full = full_q;
    assign in_ready  = rdy_q;

endmodule

// File: rtl/bmp_loader.sv
// Double-buffered bitmap loader feeding a compare engine and capturing its score.
// Build option: BMP_LOADER_LASTCHK_EN enables in_last framing checks in bmp_fill_buf.
module bmp_loader
    import bmp_pkg::*;
#(
    parameter int WORD_W = bmp_pkg::WORD_W,
    parameter int NWORDS = bmp_pkg::NWORDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [BMP_W-1:0]   bitmap,
    output logic               wren,
    input  logic [RES_W-1:0]   cmp_result,
    input  logic               cmp_done,
    output logic [RES_W-1:0]   res_data,
    output logic               res_valid,
    output logic [FRAME_W-1:0] res_frame,
    output logic               busy,
    output logic               err
);

    if (WORD_W * NWORDS != BMP_W) begin : g_cfg_check
        $error("bmp_loader: WORD_W*NWORDS must equal BMP_W");
    end

    eng_state_t         state_q, state_d;
    logic [BMP_W-1:0]   fill_data;
    logic               fill_full;
    logic               issue;
    logic               done_acc;
    logic [FRAME_W-1:0] frame_q;

    bmp_fill_buf #(
        .WORD_W (WORD_W),
        .NWORDS (NWORDS)
    ) u_fill (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .issue     (issue),
        .fill_data (fill_data),
        .fill_full (fill_full),
        .err       (err)
    );

    assign busy     = (state_q != IDLE);
    assign wren     = (state_q == ISSUE);
    assign issue    = (state_q == IDLE) && fill_full;
    assign done_acc = busy && cmp_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fill_full) state_d = ISSUE;
            ISSUE:   state_d = cmp_done ? IDLE : WAIT;
            WAIT:    if (cmp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Hold register only changes on issue, so bitmap is stable for the whole engine run
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bitmap    <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            res_frame <= '0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            res_valid <= done_acc;
            if (issue) begin
                bitmap <= fill_data;
            end
            if (done_acc) begin
                res_data  <= cmp_result;
                res_frame <= frame_q;
                frame_q   <= frame_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bmp_loader.sv
// Self-checking bench for bmp_loader: directed scenarios plus randomized traffic
// scored against a frame-level reference model.
module tb_bmp_loader;

    localparam int WW = 32;
    localparam int NW = 48;
    localparam int BW = 1536;
`ifdef BMP_LOADER_LASTCHK_EN
    localparam bit LASTCHK = 1'b1;
`else
    localparam bit LASTCHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [BW-1:0] bitmap;
    logic          wren;
    logic [15:0]   cmp_result = '0;
    logic          cmp_done = 1'b0;
    logic [15:0]   res_data;
    logic          res_valid;
    logic [7:0]    res_frame;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    bit auto_eng = 1'b0;

    // reference model state
    bit            model_on = 1'b0;
    logic [WW-1:0] m_words[$];
    logic [BW-1:0] m_frame = '0;
    logic [BW-1:0] m_held = '0;
    bit            m_full, m_busy, m_ready, m_wren, m_rv, m_err;
    bit            m_issue, m_done, m_x, m_lastpos;
    logic [15:0]   m_rd = '0;
    logic [7:0]    m_rf = '0;
    int            m_fc = 0;
    int            bad_w;
    int            wrap_seen = 0;
    logic [7:0]    prev_rf = '0;

    always #5 clk = ~clk;

    bmp_loader #(
        .WORD_W (WW),
        .NWORDS (NW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .bitmap     (bitmap),
        .wren       (wren),
        .cmp_result (cmp_result),
        .cmp_done   (cmp_done),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_frame  (res_frame),
        .busy       (busy),
        .err        (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_eng) begin
            cmp_done   = ($urandom_range(0, 5) == 0);
            cmp_result = 16'($urandom);
        end else begin
            cmp_done = 1'b0;
        end
    endtask

    task automatic send_word(input logic [WW-1:0] d, input logic last, input bit gaps);
        bit acc;
        int guard;
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        guard    = 0;
        acc      = 1'b0;
        while (!acc && guard < 2000) begin
            acc = (in_ready === 1'b1);
            tick();
            guard++;
        end
        if (!acc) check("send_timeout", 64'(guard), 64'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_wren(input string tag);
        int n;
        n = 0;
        while (wren !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, wren, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_wren"}, wren, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_res_valid"}, res_valid, 1'b0);
        check({tag, "_res_data"}, res_data, 16'h0);
        check({tag, "_res_frame"}, res_frame, 8'h0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_bitmap"}, bitmap[63:0], 64'h0);
    endtask

    // Negedge: compare DUT against the model's prediction for the last edge, then
    // advance the model using the inputs that will be sampled at the next edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("in_ready", in_ready, m_ready);
            check("wren", wren, m_wren);
            check("busy", busy, m_busy);
            check("res_valid", res_valid, m_rv);
            check("res_data", res_data, m_rd);
            check("res_frame", res_frame, m_rf);
            check("err", err, m_err);
            bad_w = 0;
            for (int k = 0; k < NW; k++) begin
                if (bitmap[k*WW +: WW] !== m_held[k*WW +: WW]) bad_w = k;
            end
            check("bitmap_word", bitmap[bad_w*WW +: WW], m_held[bad_w*WW +: WW]);
            if (res_valid === 1'b1) begin
                if (res_frame == 8'd0 && prev_rf == 8'hff) wrap_seen = 1;
                prev_rf = res_frame;
            end
        end
        if (!rst_n) begin
            m_words.delete();
            m_full   = 1'b0;
            m_busy   = 1'b0;
            m_ready  = 1'b0;
            m_wren   = 1'b0;
            m_rv     = 1'b0;
            m_err    = 1'b0;
            m_rd     = '0;
            m_rf     = '0;
            m_fc     = 0;
            m_held   = '0;
            model_on = 1'b1;
        end else if (model_on) begin
            m_issue = m_full && !m_busy;
            m_done  = (cmp_done === 1'b1) && m_busy;
            m_x     = (in_valid === 1'b1) && m_ready;
            m_wren  = m_issue;
            m_rv    = m_done;
            if (m_issue) begin
                m_held = m_frame;
                m_full = 1'b0;
                m_busy = 1'b1;
            end
            if (m_done) begin
                m_busy = 1'b0;
                m_rd   = cmp_result;
                m_rf   = 8'(m_fc);
                m_fc   = (m_fc + 1) % 256;
            end
            if (m_x) begin
                m_lastpos = (m_words.size() == NW - 1);
                if (LASTCHK && (in_last != m_lastpos)) begin
                    m_err = 1'b1;
                    m_words.delete();
                end else begin
                    m_words.push_back(in_data);
                    if (m_words.size() == NW) begin
                        for (int k = 0; k < NW; k++) m_frame[k*WW +: WW] = m_words[k];
                        m_full = 1'b1;
                        m_words.delete();
                    end
                end
            end
            m_ready = !m_full;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit after %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // reset state and release
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", in_ready, 1'b1);

        // frame of counting words, engine idle: wren two cycles after last word
        for (int k = 0; k < NW; k++) send_word(WW'(k + 1), (k == NW - 1), 1'b0);
        check("ready_full", in_ready, 1'b0);
        check("wren_lat1", wren, 1'b0);
        tick();
        check("wren_lat2", wren, 1'b1);
        check("bm_lo", bitmap[31:0], 32'h1);
        check("bm_hi", bitmap[1535:1504], 32'h30);
        check("busy_issue", busy, 1'b1);
        tick();
        check("wren_one", wren, 1'b0);
        check("busy_wait", busy, 1'b1);
        check("ready_refill", in_ready, 1'b1);

        // second frame loads while engine busy; issue waits for cmp_done
        for (int k = 0; k < NW; k++) send_word(WW'($urandom), (k == NW - 1), 1'b1);
        check("ready_f2_full", in_ready, 1'b0);
        repeat (4) begin
            tick();
            check("no_wren_busy", wren, 1'b0);
            check("hold_stable", bitmap[63:0], 64'h00000002_00000001);
        end
        cmp_result = 16'h1234;
        cmp_done   = 1'b1;
        tick();
        check("res_valid_1", res_valid, 1'b1);
        check("res_data_1", res_data, 16'h1234);
        check("res_frame_1", res_frame, 8'h0);
        check("busy_clear", busy, 1'b0);
        check("wren_turn0", wren, 1'b0);
        tick();
        check("wren_turn1", wren, 1'b1);
        check("res_valid_pulse", res_valid, 1'b0);

        // randomized traffic with a random engine, long enough to wrap the frame count
        auto_eng = 1'b1;
        for (int f = 0; f < 260; f++) begin
            for (int k = 0; k < NW; k++) begin
                send_word(WW'($urandom),
                          LASTCHK ? (k == NW - 1) : 1'($urandom_range(0, 1)), 1'b1);
            end
        end
        n = 0;
        while ((m_full || m_busy) && n < 3000) begin
            tick();
            n++;
        end
        auto_eng = 1'b0;
        tick();
        tick();
        check("drain_busy", busy, 1'b0);
        check("frame_wrap", wrap_seen, 1);

        // in_last on word 10
        for (int k = 0; k <= 10; k++) send_word(WW'($urandom), (k == 10), 1'b0);
        if (LASTCHK) begin
            repeat (3) begin
                tick();
                check("no_wren_err", wren, 1'b0);
            end
            check("err_set", err, 1'b1);
            for (int k = 0; k < NW; k++) send_word(WW'($urandom), (k == NW - 1), 1'b0);
        end else begin
            for (int k = 11; k < NW; k++) send_word(WW'($urandom), 1'b0, 1'b0);
        end
        wait_wren("wren_after_last10");
        check("err_sticky", err, LASTCHK);
        cmp_result = 16'hcafe;
        cmp_done   = 1'b1;
        tick();
        tick();

        // reset mid-frame
        for (int k = 0; k < 20; k++) send_word(WW'($urandom), 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst_midframe");
        rst_n = 1'b1;
        tick();
        check("ready_after_rst2", in_ready, 1'b1);

        // reset while the engine owns a frame; stray cmp_done afterwards
        for (int k = 0; k < NW; k++) send_word(WW'($urandom), (k == NW - 1), 1'b0);
        wait_wren("wren_before_rst");
        tick();
        check("busy_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_wait");
        rst_n = 1'b1;
        tick();
        cmp_result = 16'hbeef;
        cmp_done   = 1'b1;
        tick();
        check("stray_res_valid", res_valid, 1'b0);
        check("stray_res_data", res_data, 16'h0);
        check("stray_busy", busy, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
